enigma_key_stepper: RTL and testbench

- Upstream stage of the combinational enigma cipher core.
- Accepts ASCII keystrokes over a valid/ready handshake and maps letters to 5-bit indices (A=0..Z=25).
- Advances the three rotor positions with historical notch and double-step rules.
- Presents each letter index with the post-step rotor positions as one registered output beat; the core encrypts that beat. Position 1 is the fast (entry-side) rotor.

---
 rtl/enigma_key_stepper_if.sv | 33 +++
 rtl/enigma_key_stepper.sv | 108 ++++++++++
 tb/tb_enigma_key_stepper.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_key_stepper_if.sv
// Keystroke-in / rotor-beat-out bundle for the enigma key stepper.
// The slave modport is the stepper's view; the master modport is the driver's view.
interface enigma_key_stepper_if;
  logic        load;
  logic [4:0]  load_pos_1;
  logic [4:0]  load_pos_2;
  logic [4:0]  load_pos_3;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_char;
  logic [4:0]  out_pos_1;
  logic [4:0]  out_pos_2;
  logic [4:0]  out_pos_3;
  logic        bad_char;
  logic [15:0] key_count;

  modport slave (
    input  load, load_pos_1, load_pos_2, load_pos_3,
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char, out_pos_1, out_pos_2, out_pos_3,
    output bad_char, key_count
  );

  modport master (
    output load, load_pos_1, load_pos_2, load_pos_3,
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char, out_pos_1, out_pos_2, out_pos_3,
    input  bad_char, key_count
  );
endinterface

// File: rtl/enigma_key_stepper.sv
// Enigma key stepper: maps ASCII letters to indices, steps the three rotors
// (with optional double-step anomaly) and presents one registered beat per letter.
module enigma_key_stepper #(
  parameter int unsigned NOTCH_1     = 16,
  parameter int unsigned NOTCH_2     = 4,
  parameter bit          DOUBLE_STEP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  enigma_key_stepper_if.slave  kif
);

  localparam logic [4:0] N1 = 5'(NOTCH_1);
  localparam logic [4:0] N2 = 5'(NOTCH_2);

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-range load values fold back once (26..31 -> 0..5).
  function automatic logic [4:0] norm26(input logic [4:0] p);
    return (p >= 5'd26) ? p - 5'd26 : p;
  endfunction

  logic [4:0]  pos_1_q, pos_2_q, pos_3_q;
  logic [4:0]  pos_1_d, pos_2_d, pos_3_d;
  logic        out_valid_q;
  logic [4:0]  out_char_q, out_pos_1_q, out_pos_2_q, out_pos_3_q;
  logic        bad_char_q;
  logic [15:0] key_count_q;

  logic        accept;
  logic        is_upper, is_lower, is_letter;
  logic [4:0]  idx;
  logic        step2, step3;

  // Ready is held low in reset and during load; single output register, no skid.
  assign kif.in_ready = rst_n && !kif.load && (!out_valid_q || kif.out_ready);
  assign accept       = kif.in_valid && kif.in_ready;

  assign is_upper  = (kif.in_char >= 8'h41) && (kif.in_char <= 8'h5A);
  assign is_lower  = (kif.in_char >= 8'h61) && (kif.in_char <= 8'h7A);
  assign is_letter = is_upper || is_lower;
  assign idx       = is_upper ? 5'(kif.in_char - 8'h41) : 5'(kif.in_char - 8'h61);

  // Stepping decisions use the pre-step positions; the machine steps before contact.
  always_comb begin
    step2   = (pos_1_q == N1) || (DOUBLE_STEP && (pos_2_q == N2));
    step3   = (pos_2_q == N2);
    pos_1_d = inc26(pos_1_q);
    pos_2_d = step2 ? inc26(pos_2_q) : pos_2_q;
    pos_3_d = step3 ? inc26(pos_3_q) : pos_3_q;
  end

  // Rotor positions and letter counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_1_q     <= '0;
      pos_2_q     <= '0;
      pos_3_q     <= '0;
      key_count_q <= '0;
    end else if (kif.load) begin
      pos_1_q     <= norm26(kif.load_pos_1);
      pos_2_q     <= norm26(kif.load_pos_2);
      pos_3_q     <= norm26(kif.load_pos_3);
      key_count_q <= '0;
    end else if (accept && is_letter) begin
      pos_1_q     <= pos_1_d;
      pos_2_q     <= pos_2_d;
      pos_3_q     <= pos_3_d;
      key_count_q <= key_count_q + 16'd1;
    end
  end

  // Output beat register: loads on a letter, clears on handshake, else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_pos_1_q <= '0;
      out_pos_2_q <= '0;
      out_pos_3_q <= '0;
    end else if (accept && is_letter) begin
      out_valid_q <= 1'b1;
      out_char_q  <= idx;
      out_pos_1_q <= pos_1_d;
      out_pos_2_q <= pos_2_d;
      out_pos_3_q <= pos_3_d;
    end else if (kif.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-cycle flag for a consumed non-letter byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bad_char_q <= 1'b0;
    else        bad_char_q <= accept && !is_letter;
  end

  assign kif.out_valid = out_valid_q;
  assign kif.out_char  = out_char_q;
  assign kif.out_pos_1 = out_pos_1_q;
  assign kif.out_pos_2 = out_pos_2_q;
  assign kif.out_pos_3 = out_pos_3_q;
  assign kif.bad_char  = bad_char_q;
  assign kif.key_count = key_count_q;

endmodule

// File: tb/tb_enigma_key_stepper.sv
// Directed + randomized bench for enigma_key_stepper with a beat scoreboard.
module tb_enigma_key_stepper;

  localparam logic [4:0] N1 = 5'd16;
  localparam logic [4:0] N2 = 5'd4;
  localparam bit         DS = 1'b1;

  typedef struct packed {
    logic [4:0] c;
    logic [4:0] p1;
    logic [4:0] p2;
    logic [4:0] p3;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enigma_key_stepper_if kif();

  enigma_key_stepper #(.NOTCH_1(16), .NOTCH_2(4), .DOUBLE_STEP(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  int          errors = 0;
  int          checks = 0;
  beat_t       sb[$];
  logic [4:0]  m1, m2, m3;
  logic [15:0] m_kc;
  logic        bad_exp;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] fold(input logic [4:0] p);
    return (p > 5'd25) ? p - 5'd26 : p;
  endfunction

  task automatic model_reset();
    sb.delete();
    m1 = 0; m2 = 0; m3 = 0; m_kc = 0; bad_exp = 0;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    beat_t      b;
    logic       rdy, s2, s3, up, lo;
    logic [4:0] ix;
    #1;
    chk("out_valid", 16'(kif.out_valid), 16'(sb.size() != 0));
    chk("bad_char", 16'(kif.bad_char), 16'(bad_exp));
    chk("key_count", kif.key_count, m_kc);
    rdy = !kif.load && (sb.size() == 0 || kif.out_ready);
    chk("in_ready", 16'(kif.in_ready), 16'(rdy));
    if (sb.size() != 0) begin
      b = sb[0];
      chk("out_char", 16'(kif.out_char), 16'(b.c));
      chk("out_pos_1", 16'(kif.out_pos_1), 16'(b.p1));
      chk("out_pos_2", 16'(kif.out_pos_2), 16'(b.p2));
      chk("out_pos_3", 16'(kif.out_pos_3), 16'(b.p3));
      if (kif.out_ready) void'(sb.pop_front());
    end
    bad_exp = 1'b0;
    if (kif.load) begin
      m1 = fold(kif.load_pos_1);
      m2 = fold(kif.load_pos_2);
      m3 = fold(kif.load_pos_3);
      m_kc = 0;
    end else if (kif.in_valid && rdy) begin
      up = (kif.in_char >= 8'h41) && (kif.in_char <= 8'h5A);
      lo = (kif.in_char >= 8'h61) && (kif.in_char <= 8'h7A);
      if (up || lo) begin
        ix = up ? 5'(kif.in_char - 8'h41) : 5'(kif.in_char - 8'h61);
        s2 = (m1 == N1) || (DS && m2 == N2);
        s3 = (m2 == N2);
        m1 = inc26(m1);
        if (s2) m2 = inc26(m2);
        if (s3) m3 = inc26(m3);
        sb.push_back('{c: ix, p1: m1, p2: m2, p3: m3});
        m_kc = m_kc + 16'd1;
      end else begin
        bad_exp = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] ch);
    kif.in_valid = 1'b1;
    kif.in_char  = ch;
    tick();
    kif.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    kif.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    kif.load = 1'b1;
    kif.load_pos_1 = a; kif.load_pos_2 = b; kif.load_pos_3 = c;
    tick();
    kif.load = 1'b0;
  endtask

  initial begin
    logic [7:0] ch;
    kif.load = 0; kif.load_pos_1 = 0; kif.load_pos_2 = 0; kif.load_pos_3 = 0;
    kif.in_valid = 0; kif.in_char = 0; kif.out_ready = 1;
    model_reset();

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_in_ready", 16'(kif.in_ready), 16'd0);
    chk("rst_out_valid", 16'(kif.out_valid), 16'd0);
    chk("rst_out_pos_1", 16'(kif.out_pos_1), 16'd0);
    chk("rst_key_count", kif.key_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First letter from (0,0,0)
    send(8'h41);
    idle(1);

    // Notch on rotor 1
    do_load(5'd16, 5'd0, 5'd0);
    send("q");
    send("Q");
    idle(1);

    // Double step, back-to-back throughput
    do_load(5'd16, 5'd3, 5'd0);
    send("a"); send("b"); send("c");
    idle(2);

    // Wrap and out-of-range load values
    do_load(5'd25, 5'd25, 5'd25);
    send("Z");
    idle(1);
    do_load(5'd31, 5'd30, 5'd26);
    send("a");
    idle(1);

    // Backpressure
    kif.out_ready = 1'b0;
    send("B");
    for (int i = 0; i < 3; i++) send("C");
    kif.out_ready = 1'b1;
    send("C");
    idle(2);

    // Non-letter consumed
    send(8'h20);
    idle(2);
    send(8'h7B);
    idle(1);

    // Load beats a waiting key; pending beat survives a load
    kif.out_ready = 1'b0;
    send("E");
    kif.in_valid = 1'b1; kif.in_char = "D";
    kif.load = 1'b1; kif.load_pos_1 = 5'd2; kif.load_pos_2 = 5'd4; kif.load_pos_3 = 5'd7;
    tick();
    kif.load = 1'b0;
    kif.out_ready = 1'b1;
    tick();
    idle(2);

    // Randomized traffic with backpressure and occasional loads
    for (int i = 0; i < 200; i++) begin
      kif.in_valid  = ($urandom_range(0, 3) != 0);
      kif.out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       ch = 8'(8'h5B + $urandom_range(0, 5));
        1, 2, 3: ch = 8'(8'h61 + $urandom_range(0, 25));
        default: ch = 8'(8'h41 + $urandom_range(0, 25));
      endcase
      kif.in_char = ch;
      kif.load = ($urandom_range(0, 19) == 0);
      kif.load_pos_1 = 5'($urandom_range(0, 31));
      kif.load_pos_2 = 5'($urandom_range(0, 31));
      kif.load_pos_3 = 5'($urandom_range(0, 31));
      tick();
    end
    kif.load = 1'b0;
    kif.out_ready = 1'b1;
    idle(3);

    // Async reset with a beat pending
    kif.out_ready = 1'b0;
    send("K");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 16'(kif.out_valid), 16'd0);
    chk("arst_in_ready", 16'(kif.in_ready), 16'd0);
    chk("arst_out_pos_1", 16'(kif.out_pos_1), 16'd0);
    chk("arst_key_count", kif.key_count, 16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    kif.out_ready = 1'b1;
    send("A");
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
